pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 49 ++++
 rtl/ras_stack.sv | 74 +++++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared definitions for the program-counter sequencer:
//                command encoding, priority resolution and the width helper
//                for the return-address-stack occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Resolved command for the current cycle, one value per command.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_INC    = 3'd1,
        CMD_BRANCH = 3'd2,
        CMD_JUMP   = 3'd3,
        CMD_CALL   = 3'd4,
        CMD_RET    = 3'd5,
        CMD_STALL  = 3'd6
    } cmd_e;

    // Number of distinct resolved commands.
    localparam int unsigned CMD_NUM = 7;

    // The count must be able to represent 0..DEPTH inclusive.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Fixed priority: stall > ret > call > jump > branch > inc.
    function automatic cmd_e decode_cmd(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jump,
        input logic branch,
        input logic inc
    );
        if (stall)       return CMD_STALL;
        else if (ret)    return CMD_RET;
        else if (call)   return CMD_CALL;
        else if (jump)   return CMD_JUMP;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_NONE;
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Return-address stack. The top entry is presented
//                combinationally so a pop in the cycle right after a push
//                returns the freshly written address. Pushes into a full
//                stack and pops from an empty stack are ignored; the parent
//                reports those as errors.
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Push wins if both are requested; the parent never asks for both.
    assign do_push = push_i & ~full_o & ~rst;
    assign do_pop  = pop_i & ~push_i & ~empty_o;

    // Next free slot equals the count; the top sits one below it.
    assign wr_ptr  = PTR_W'(count_q);
    assign rd_ptr  = PTR_W'(count_q - CNT_W'(1));
    assign data_o  = mem_q[rd_ptr];
    assign count_o = count_q;

    // Occupancy update from the accepted push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push)
            count_d = count_q + CNT_W'(1);
        else if (do_pop)
            count_d = count_q - CNT_W'(1);
    end

    // Occupancy register; reset empties the stack logically.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr] <= data_i;
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer with increment, absolute jump,
//                relative branch, call/return through a return-address
//                stack, stall, and sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter int                 OFF_W      = 8,
    parameter int                 RAS_DEPTH  = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           inc,
    input  logic                           jump,
    input  logic                           branch,
    input  logic                           call,
    input  logic                           ret,
    input  logic [ADDR_W-1:0]              target,
    input  logic [OFF_W-1:0]               offset,
    output logic [ADDR_W-1:0]              pc,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count,
    output logic                           ras_full,
    output logic                           ras_empty,
    output logic                           ovf_err,
    output logic                           unf_err
);

    localparam int CNT_W = ras_cnt_w(RAS_DEPTH);

    cmd_e              cmd;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;

    assign cmd      = decode_cmd(stall, ret, call, jump, branch, inc);
    assign pc_plus1 = pc_q + ADDR_W'(1);

    // Sign-extend the branch displacement to the PC width.
    generate
        if (OFF_W < ADDR_W) begin : g_off_sext
            assign off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
        end else begin : g_off_full
            assign off_ext = offset;
        end
    endgenerate

    ras_stack #(
        .DEPTH  (RAS_DEPTH),
        .DATA_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_plus1),
        .data_o  (ras_top),
        .count_o (ras_count),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    // Next PC, stack requests and error flags for the selected command.
    always_comb begin
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (cmd)
            CMD_RET: begin
                if (ras_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end
            CMD_CALL: begin
                pc_d = target;
                if (ras_full)
                    ovf_d = 1'b1;
                else
                    ras_push = 1'b1;
            end
            CMD_JUMP:   pc_d = target;
            CMD_BRANCH: pc_d = pc_q + off_ext;
            CMD_INC:    pc_d = pc_plus1;
            default:    pc_d = pc_q;
        endcase
    end

    // PC and sticky error flags; reset overrides every command.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_ADDR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule : pc_sequencer
`default_nettype wire
